tag_demux_csdf: RTL and testbench



---
 rtl/tag_demux_csdf_pkg.sv | 16 +
 rtl/tag_demux_csdf_if.sv | 28 ++
 rtl/tag_demux_csdf_fifo.sv | 40 ++++
 rtl/tag_demux_csdf.sv | 69 ++++++
 tb/tb_tag_demux_csdf.sv | 134 +++++++++++++
 5 files changed

// File: rtl/tag_demux_csdf_pkg.sv
// csdf_pkg: width derivations, stats counter width and saturating increment for the tag demux
package csdf_pkg;
    localparam int STAT_W = 16;

    function automatic int tag_w(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int data_w(input int width, input int flux);
        return width - tag_w(flux);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/tag_demux_csdf_if.sv
// tag_demux_csdf_if: tagged input stream plus per-flux output channels (stats ports with TAG_DEMUX_STATS_EN)
interface tag_demux_csdf_if
    import csdf_pkg::*;
#(
    parameter int FLUX  = 2,
    parameter int WIDTH = 8
);
    localparam int DW = data_w(WIDTH, FLUX);
    logic                 in0_wr;
    logic [WIDTH-1:0]     in0_data;
    logic                 in0_full;
    logic [FLUX-1:0]      out_wr;
    logic [DW*FLUX-1:0]   out_data;
    logic [FLUX-1:0]      out_full;
`ifdef TAG_DEMUX_STATS_EN
    logic [STAT_W-1:0]      drop_cnt;
    logic [STAT_W*FLUX-1:0] tok_cnt;
    modport slave (input in0_wr, in0_data, out_full,
                   output in0_full, out_wr, out_data, drop_cnt, tok_cnt);
    modport master (output in0_wr, in0_data, out_full,
                    input in0_full, out_wr, out_data, drop_cnt, tok_cnt);
`else
    modport slave (input in0_wr, in0_data, out_full,
                   output in0_full, out_wr, out_data);
    modport master (output in0_wr, in0_data, out_full,
                    input in0_full, out_wr, out_data);
`endif
endinterface

// File: rtl/tag_demux_csdf_fifo.sv
// csdf_flux_fifo: DEPTH-entry circular buffer for one flux; reads zero while empty
module csdf_flux_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 7
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok, pop_ok;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    // storage needs no reset: contents are only visible while cnt is non-zero
    always_ff @(posedge ck) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/tag_demux_csdf.sv
// tag_demux_csdf: routes tagged words to per-flux buffered output channels
// Optional TAG_DEMUX_STATS_EN adds saturating drop and per-flux token counters.
module tag_demux_csdf
    import csdf_pkg::*;
#(
    parameter int FLUX  = 2,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic ck,
    input  logic rst,
    tag_demux_csdf_if.slave bus
);
    localparam int TW = tag_w(FLUX);
    localparam int DW = data_w(WIDTH, FLUX);
    logic [TW-1:0]   tag;
    logic [DW-1:0]   payload;
    logic            valid_tag, in_full, accept;
    logic [FLUX-1:0] push, owr, full_v, empty_v;
    logic [DW-1:0]   dout [FLUX];
    logic [FLUX-1:0][DW-1:0] dpack;
    assign tag       = bus.in0_data[WIDTH-1 -: TW];
    assign payload   = bus.in0_data[DW-1:0];
    assign valid_tag = int'(tag) < FLUX;
    // full is register-only so the upstream can derive its write from it safely
    assign in_full   = |full_v;
    assign accept    = bus.in0_wr & ~in_full & valid_tag;
    always_comb begin
        push  = '0;
        owr   = '0;
        dpack = '0;
        for (int i = 0; i < FLUX; i++) begin
            push[i]  = accept && (int'(tag) == i);
            owr[i]   = ~empty_v[i] & ~bus.out_full[i];
            dpack[i] = dout[i];
        end
    end
    assign bus.in0_full = in_full;
    assign bus.out_wr   = owr;
    assign bus.out_data = dpack;
    for (genvar g = 0; g < FLUX; g++) begin : g_flux
        csdf_flux_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
            .ck    (ck),
            .rst   (rst),
            .push  (push[g]),
            .pop   (owr[g]),
            .din   (payload),
            .dout  (dout[g]),
            .full  (full_v[g]),
            .empty (empty_v[g])
        );
    end
`ifdef TAG_DEMUX_STATS_EN
    logic [STAT_W-1:0]           drop_q;
    logic [FLUX-1:0][STAT_W-1:0] tok_q;
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
            tok_q  <= '0;
        end else begin
            if (bus.in0_wr & (in_full | ~valid_tag)) drop_q <= sat_inc(drop_q);
            for (int i = 0; i < FLUX; i++)
                if (push[i]) tok_q[i] <= sat_inc(tok_q[i]);
        end
    end
    assign bus.drop_cnt = drop_q;
    assign bus.tok_cnt  = tok_q;
`endif
endmodule

// File: tb/tb_tag_demux_csdf.sv
// tb_tag_demux_csdf: directed checks of routing, backpressure, concurrency, invalid tags and async reset
module tb_tag_demux_csdf;
    logic ck = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 ck = ~ck;

    tag_demux_csdf_if #(.FLUX(2), .WIDTH(8)) bus ();
    tag_demux_csdf_if #(.FLUX(3), .WIDTH(8)) bus3 ();

    tag_demux_csdf #(.FLUX(2), .WIDTH(8), .DEPTH(4)) dut (.ck(ck), .rst(rst), .bus(bus));
    tag_demux_csdf #(.FLUX(3), .WIDTH(8), .DEPTH(4)) dut3 (.ck(ck), .rst(rst), .bus(bus3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ck);
    endtask

    task automatic put(input logic wr, input logic [7:0] d);
        bus.in0_wr   = wr;
        bus.in0_data = d;
    endtask

    logic [7:0] cin [9];
    logic       cwr [9];
    logic [1:0] cowr [9];
    logic [6:0] cd0 [9], cd1 [9];

    initial begin
        bus.in0_wr = 1'b0; bus.in0_data = '0; bus.out_full = '0;
        bus3.in0_wr = 1'b0; bus3.in0_data = '0; bus3.out_full = '0;
        step();
        #1;
        check("reset_out_wr", 32'(bus.out_wr), 32'h0);
        check("reset_in0_full", 32'(bus.in0_full), 32'h0);
        check("reset_out_data", 32'(bus.out_data), 32'h0);
        step();
        rst = 1'b1;

        // single word to flux 1
        step(); put(1'b1, 8'h85);
        #1 check("single_before", 32'(bus.out_wr), 32'h0);
        step(); put(1'b0, 8'h00);
        #1 check("single_out_wr", 32'(bus.out_wr), 32'h2);
        check("single_data", 32'(bus.out_data), {18'h0, 7'h05, 7'h00});
        step();
        #1 check("single_empty_wr", 32'(bus.out_wr), 32'h0);
        check("single_empty_data", 32'(bus.out_data), 32'h0);

        // fill flux 0 under backpressure
        bus.out_full = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            step(); put(1'b1, 8'(i));
            #1 check("fill_not_full", 32'(bus.in0_full), 32'h0);
        end
        step(); put(1'b1, 8'h7F);
        #1 check("fill_full", 32'(bus.in0_full), 32'h1);
        check("fill_blocked_wr", 32'(bus.out_wr), 32'h0);
        step(); put(1'b0, 8'h00); bus.out_full = 2'b00;
        #1 check("drain_full_still", 32'(bus.in0_full), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                step();
                #1 check("drain_full_clear", 32'(bus.in0_full), 32'h0);
            end
            check("drain_wr", 32'(bus.out_wr), 32'h1);
            check("drain_data", 32'(bus.out_data), 32'(i));
        end
        step();
        #1 check("drain_done", 32'(bus.out_wr), 32'h0);
`ifdef TAG_DEMUX_STATS_EN
        check("stats_tok0", 32'(bus.tok_cnt[15:0]), 32'd4);
        check("stats_tok1", 32'(bus.tok_cnt[31:16]), 32'd1);
        check("stats_drop", 32'(bus.drop_cnt), 32'd1);
`endif

        // concurrent push/pop with interleaved flux-1 words
        cin  = '{8'h10, 8'h11, 8'h12, 8'h81, 8'h14, 8'h82, 8'h15, 8'h00, 8'h00};
        cwr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cowr = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        cd0  = '{7'h00, 7'h10, 7'h11, 7'h12, 7'h00, 7'h14, 7'h00, 7'h15, 7'h00};
        cd1  = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h01, 7'h00, 7'h02, 7'h00, 7'h00};
        for (int k = 0; k < 9; k++) begin
            step(); put(cwr[k], cin[k]);
            #1 check("conc_wr", 32'(bus.out_wr), 32'(cowr[k]));
            check("conc_data", 32'(bus.out_data), {18'h0, cd1[k], cd0[k]});
            check("conc_full", 32'(bus.in0_full), 32'h0);
        end

        // invalid tag on the three-flux instance
        step(); bus3.in0_wr = 1'b1; bus3.in0_data = 8'hC3;
        step(); bus3.in0_data = 8'h85;
        #1 check("badtag_no_wr", 32'(bus3.out_wr), 32'h0);
        check("badtag_no_data", 32'(bus3.out_data), 32'h0);
        step(); bus3.in0_wr = 1'b0;
        #1 check("tag2_wr", 32'(bus3.out_wr), 32'h4);
        check("tag2_data", 32'(bus3.out_data), 32'h05000);
`ifdef TAG_DEMUX_STATS_EN
        check("badtag_drop", 32'(bus3.drop_cnt), 32'd1);
`endif

        // asynchronous reset with flux 1 full and stalled
        bus.out_full = 2'b10;
        for (int i = 1; i <= 4; i++) begin
            step(); put(1'b1, 8'h80 | 8'(i));
        end
        step(); put(1'b0, 8'h00);
        #1 check("prerst_full", 32'(bus.in0_full), 32'h1);
        #2 rst = 1'b0; bus.out_full = 2'b00;
        #1 check("rst_out_wr", 32'(bus.out_wr), 32'h0);
        check("rst_in0_full", 32'(bus.in0_full), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        step(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            #1 check("postrst_no_stale", 32'(bus.out_wr), 32'h0);
        end
`ifdef TAG_DEMUX_STATS_EN
        check("postrst_drop", 32'(bus.drop_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
